// File: rtl/sobel_window_sequencer.sv
// sobel_window_sequencer
// Streams a raster-order grayscale frame through two line buffers into a 3x3
// window, presents the nine taps to an external Sobel operator, and re-times
// the operator's registered result against the centre-pixel coordinates.
// Border centres are forced to zero. After the last pixel, the block injects
// IMG_WIDTH+1 zero pixels to push the final windows out.
//
// Ports
//   clk, reset_n       : single clock, asynchronous active-low reset
//   frame_start        : start pulse, honoured only while idle
//   in_valid/in_data   : input pixel stream, accepted when in_ready is high
//   in_ready           : high in FILL and RUN
//   p1..p9             : registered window taps (p1 top-left, p5 centre)
//   sobel_q            : operator result, registered one cycle after the taps
//   out_valid/out_data : result strobe and value (zero on border centres)
//   out_border         : centre of this result lies on the image border
//   busy               : frame in progress
//   frame_done         : one-cycle pulse after the final result
module sobel_window_sequencer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int WORD_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] p1,
    output logic [WORD_SIZE-1:0] p2,
    output logic [WORD_SIZE-1:0] p3,
    output logic [WORD_SIZE-1:0] p4,
    output logic [WORD_SIZE-1:0] p5,
    output logic [WORD_SIZE-1:0] p6,
    output logic [WORD_SIZE-1:0] p7,
    output logic [WORD_SIZE-1:0] p8,
    output logic [WORD_SIZE-1:0] p9,
    input  logic [WORD_SIZE-1:0] sobel_q,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_border,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int XW = $clog2(IMG_WIDTH);
    // in_y keeps counting through the flush, so it needs room beyond the last line
    localparam int YW = $clog2(IMG_HEIGHT + 2);
    localparam int FW = $clog2(IMG_WIDTH + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] F_LAST = FW'(IMG_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [XW-1:0]          in_x_r;
    logic [YW-1:0]          in_y_r;
    logic [XW-1:0]          out_x_r;
    logic [YW-1:0]          out_y_r;
    logic [FW-1:0]          flush_cnt_r;
    logic                   drain_cnt_r;
    logic                   in_ready_r;
    logic                   busy_r;
    logic                   frame_done_r;
    logic [WORD_SIZE-1:0]   lb0_r [IMG_WIDTH];
    logic [WORD_SIZE-1:0]   lb1_r [IMG_WIDTH];
    logic [WORD_SIZE-1:0]   w00_r, w01_r, w02_r;
    logic [WORD_SIZE-1:0]   w10_r, w11_r, w12_r;
    logic [WORD_SIZE-1:0]   w20_r, w21_r, w22_r;
    logic                   s1_valid_r;
    logic                   s1_border_r;
    logic                   out_valid_r;
    logic                   out_border_r;

    logic                   event_s;
    logic                   result_s;
    logic                   border_s;
    logic [WORD_SIZE-1:0]   pixel_s;

    // Window event source: accepted pixel while streaming, injected zero while flushing
    always_comb begin
        event_s = 1'b0;
        pixel_s = {WORD_SIZE{1'b0}};
        case (state_r)
            S_FILL, S_RUN: begin
                event_s = in_valid && in_ready_r;
                pixel_s = in_data;
            end
            S_FLUSH: begin
                event_s = 1'b1;
                pixel_s = {WORD_SIZE{1'b0}};
            end
            default: begin
                event_s = 1'b0;
                pixel_s = {WORD_SIZE{1'b0}};
            end
        endcase
    end

    // Result bookkeeping: the first IMG_WIDTH+1 events (FILL) only prime the window
    always_comb begin
        result_s = event_s && ((state_r == S_RUN) || (state_r == S_FLUSH));
        border_s = (out_x_r == {XW{1'b0}}) || (out_x_r == X_LAST) ||
                   (out_y_r == {YW{1'b0}}) || (out_y_r == Y_LAST);
    end

    // Next-state decode; FILL ends on the event for pixel (0,1), i.e. event IMG_WIDTH
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (frame_start) state_s = S_FILL;
                else             state_s = S_IDLE;
            end
            S_FILL: begin
                if (event_s && (in_x_r == {XW{1'b0}}) && (in_y_r == YW'(1))) state_s = S_RUN;
                else                                                         state_s = S_FILL;
            end
            S_RUN: begin
                if (event_s && (in_x_r == X_LAST) && (in_y_r == Y_LAST)) state_s = S_FLUSH;
                else                                                      state_s = S_RUN;
            end
            S_FLUSH: begin
                if (flush_cnt_r == F_LAST) state_s = S_DRAIN;
                else                       state_s = S_FLUSH;
            end
            S_DRAIN: begin
                if (drain_cnt_r) state_s = S_IDLE;
                else             state_s = S_DRAIN;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register, registered status outputs and coordinate counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            in_x_r       <= {XW{1'b0}};
            in_y_r       <= {YW{1'b0}};
            out_x_r      <= {XW{1'b0}};
            out_y_r      <= {YW{1'b0}};
            flush_cnt_r  <= {FW{1'b0}};
            drain_cnt_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            // Decoded from the next state so in_ready/busy line up with state_r
            in_ready_r   <= (state_s == S_FILL) || (state_s == S_RUN);
            busy_r       <= (state_s != S_IDLE);
            frame_done_r <= (state_r == S_DRAIN) && drain_cnt_r;
            if (state_r == S_IDLE) begin
                in_x_r      <= {XW{1'b0}};
                in_y_r      <= {YW{1'b0}};
                out_x_r     <= {XW{1'b0}};
                out_y_r     <= {YW{1'b0}};
                flush_cnt_r <= {FW{1'b0}};
                drain_cnt_r <= 1'b0;
            end else begin
                if (event_s) begin
                    if (in_x_r == X_LAST) begin
                        in_x_r <= {XW{1'b0}};
                        in_y_r <= in_y_r + YW'(1);
                    end else begin
                        in_x_r <= in_x_r + XW'(1);
                    end
                end
                if (result_s) begin
                    if (out_x_r == X_LAST) begin
                        out_x_r <= {XW{1'b0}};
                        out_y_r <= out_y_r + YW'(1);
                    end else begin
                        out_x_r <= out_x_r + XW'(1);
                    end
                end
                if (state_r == S_FLUSH) flush_cnt_r <= flush_cnt_r + FW'(1);
                if (state_r == S_DRAIN) drain_cnt_r <= ~drain_cnt_r;
            end
        end
    end

    // Line buffers carry no reset: stale contents only ever reach border centres
    always_ff @(posedge clk) begin
        if (event_s) begin
            lb1_r[in_x_r] <= lb0_r[in_x_r];
            lb0_r[in_x_r] <= pixel_s;
        end
    end

    // Window shift plus the two-stage valid/border pipeline matching the operator latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w00_r <= {WORD_SIZE{1'b0}}; w01_r <= {WORD_SIZE{1'b0}}; w02_r <= {WORD_SIZE{1'b0}};
            w10_r <= {WORD_SIZE{1'b0}}; w11_r <= {WORD_SIZE{1'b0}}; w12_r <= {WORD_SIZE{1'b0}};
            w20_r <= {WORD_SIZE{1'b0}}; w21_r <= {WORD_SIZE{1'b0}}; w22_r <= {WORD_SIZE{1'b0}};
            s1_valid_r   <= 1'b0;
            s1_border_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_border_r <= 1'b0;
        end else begin
            if (event_s) begin
                w00_r <= w01_r; w01_r <= w02_r; w02_r <= lb1_r[in_x_r];
                w10_r <= w11_r; w11_r <= w12_r; w12_r <= lb0_r[in_x_r];
                w20_r <= w21_r; w21_r <= w22_r; w22_r <= pixel_s;
            end
            s1_valid_r   <= result_s;
            s1_border_r  <= result_s && border_s;
            out_valid_r  <= s1_valid_r;
            out_border_r <= s1_valid_r && s1_border_r;
        end
    end

    assign p1 = w00_r;
    assign p2 = w01_r;
    assign p3 = w02_r;
    assign p4 = w10_r;
    assign p5 = w11_r;
    assign p6 = w12_r;
    assign p7 = w20_r;
    assign p8 = w21_r;
    assign p9 = w22_r;

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign out_valid  = out_valid_r;
    assign out_border = out_border_r;
    // sobel_q is already registered downstream; only a gating mux sits on this path
    assign out_data   = (out_valid_r && !out_border_r) ? sobel_q : {WORD_SIZE{1'b0}};

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Self-checking bench for sobel_window_sequencer (8x6 frame, 8-bit pixels).
// Emulates the downstream Sobel operator, predicts every result from the
// frame image, and checks results from a separate monitor process.
module tb_sobel_window_sequencer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int WS = 8;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [WS-1:0] in_data = 8'd0;
    logic          in_ready;
    logic [WS-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic [WS-1:0] sobel_q = 8'd0;
    logic          out_valid;
    logic [WS-1:0] out_data;
    logic          out_border;
    logic          busy;
    logic          frame_done;

    typedef struct packed {
        logic [7:0]  data;
        logic        border;
        logic [71:0] taps;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   results_seen = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   img[N];

    sobel_window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .WORD_SIZE(WS)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
        .sobel_q(sobel_q), .out_valid(out_valid), .out_data(out_data),
        .out_border(out_border), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sobel9(input int q[9]);
        int gx, gy, m;
        gx = (q[2] + 2*q[5] + q[8]) - (q[0] + 2*q[3] + q[6]);
        gy = (q[6] + 2*q[7] + q[8]) - (q[0] + 2*q[1] + q[2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        return m;
    endfunction

    function automatic int sobel_taps(input logic [71:0] t);
        int q[9];
        for (int i = 0; i < 9; i++) q[i] = int'(t[(8-i)*8 +: 8]);
        return sobel9(q);
    endfunction

    // Downstream operator: registers its result one cycle after the taps
    always @(posedge clk) sobel_q <= WS'(sobel_taps({p1, p2, p3, p4, p5, p6, p7, p8, p9}));

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one entry per pixel in raster order
    task automatic push_expected();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                exp_t e;
                int   q[9];
                e.border = (x == 0) || (x == W-1) || (y == 0) || (y == H-1);
                e.data   = 8'd0;
                e.taps   = 72'd0;
                if (!e.border) begin
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++) begin
                            q[r*3+c] = img[(y-1+r)*W + (x-1+c)];
                            e.taps   = {e.taps[63:0], 8'(q[r*3+c])};
                        end
                    e.data = 8'(sobel9(q));
                end
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every out_valid, checks frame_done placement
    initial begin
        exp_t        e;
        logic [71:0] prev_taps = 72'd0;
        logic        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                results_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out_valid: got out_data %0d with empty scoreboard at t=%0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_border", out_border, e.border);
                    if (!e.border) check("taps", prev_taps, e.taps);
                end
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_after_last_valid", prev_valid, 1);
                check("queue_empty_at_done", exp_q.size(), 0);
            end
            prev_taps  = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
            prev_valid = out_valid;
        end
    end

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_border", out_border, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_taps", {p1, p2, p3, p4, p5, p6, p7, p8, p9}, 0);
    endtask

    // pat: 0 random, 1 ramp 1..N, 2 constant 50, 3 vertical step
    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random
    // poke: frame_start mid-RUN and in_valid held through FLUSH
    // abort_at: >0 asserts reset after that many accepted pixels
    task automatic run_frame(input int pat, input int gap_mode, input bit poke, input int abort_at);
        int idx, budget, last_acc, d0, r0, stop;
        for (int i = 0; i < N; i++) begin
            case (pat)
                1:       img[i] = i + 1;
                2:       img[i] = 50;
                3:       img[i] = ((i % W) < W/2) ? 0 : 100;
                default: img[i] = int'($urandom_range(0, 255));
            endcase
        end
        push_expected();
        d0 = done_cnt;
        r0 = results_seen;
        last_acc = 0;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        check("in_ready_after_start", in_ready, 1);
        check("busy_after_start", busy, 1);
        stop = (abort_at > 0) ? abort_at : N;
        idx = 0;
        budget = 0;
        while (idx < stop && budget < 20*N) begin
            case (gap_mode)
                1:       in_valid = (budget % 2 == 0);
                2:       in_valid = ($urandom_range(0, 2) != 0);
                default: in_valid = 1'b1;
            endcase
            in_data     = 8'(img[idx]);
            frame_start = poke && (idx == N/2);
            if (in_valid && in_ready) begin
                idx++;
                last_acc = cyc;
            end
            budget++;
            @(negedge clk);
        end
        frame_start = 1'b0;
        check("all_pixels_accepted", idx, stop);
        if (abort_at > 0) begin
            in_valid = 1'b0;
            #1 reset_n = 1'b0;
            exp_q.delete();
            #1 check_reset_outputs();
            @(negedge clk);
            #1 reset_n = 1'b1;
            repeat (12) @(negedge clk);
            check("no_done_after_abort", done_cnt - d0, 0);
            check("idle_after_abort", busy, 0);
        end else begin
            in_valid = poke;
            in_data  = 8'($urandom_range(0, 255));
            budget = 0;
            while (done_cnt == d0 && budget < 4*W + 20) begin
                if (poke) check("in_ready_low_after_last", in_ready, 0);
                @(negedge clk);
                budget++;
            end
            in_valid = 1'b0;
            check("frame_done_seen", done_cnt - d0, 1);
            check("done_latency", done_cyc - last_acc, W + 4);
            repeat (4) @(negedge clk);
            check("result_count", results_seen - r0, N);
            check("single_frame_done", done_cnt - d0, 1);
            check("idle_after_frame", busy, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        run_frame(1, 0, 1'b0, 0);
        run_frame(1, 1, 1'b0, 0);
        run_frame(2, 0, 1'b0, 0);
        run_frame(3, 0, 1'b0, 0);
        run_frame(0, 2, 1'b0, 0);
        run_frame(0, 0, 1'b0, 2*W + 5);
        run_frame(0, 2, 1'b0, 0);
        run_frame(0, 2, 1'b1, 0);
        run_frame(0, 0, 1'b1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
